// File: rtl/poly_compress.sv
// poly_compress: Kyber512 v-component compressor.
// Latches a 256-coefficient polynomial (12-bit coefficients), maps each
// coefficient to 3 bits with t = (((x << 3) + 1664) / 3329) & 7 and packs
// the 3-bit values contiguously (LSB first) into a 96-byte output field.
// Build option: define POLY_COMPRESS_DOUBLE_RATE_EN to process two groups
// of 8 coefficients per clock (16 compress units) instead of one.
//
// state | meaning
// IDLE  | waiting for enable; output holds last completed result
// CALC  | compressing one (or two) groups of 8 coefficients per edge
// DONE  | publish packed buffer to oPoly_Compressed, pulse out_ready
module poly_compress #(
  parameter int KYBER_N                   = 256,
  parameter int KYBER_Q                   = 3329,
  parameter int KYBER_POLYCOMPRESSEDBYTES = 96,
  parameter int data_Width                = 12,
  parameter int Byte_bits                 = 8,
  parameter int i_Poly_Size               = data_Width * KYBER_N,
  parameter int o_Poly_Compressed_Size    = Byte_bits * KYBER_POLYCOMPRESSEDBYTES
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [i_Poly_Size-1:0]            iPoly,
  output logic                              busy,
  output logic                              out_ready,
  output logic [o_Poly_Compressed_Size-1:0] oPoly_Compressed
);

`ifdef POLY_COMPRESS_DOUBLE_RATE_EN
  localparam int GPC = 2;
`else
  localparam int GPC = 1;
`endif
  localparam int COEF_PER_STEP = 8 * GPC;
  localparam int STEP_BITS     = 3 * COEF_PER_STEP;
  localparam int STEPS         = KYBER_N / COEF_PER_STEP;
  localparam int CNT_W         = $clog2(STEPS);
  localparam logic [CNT_W-1:0] G_LAST = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                            state_q, state_d;
  logic [CNT_W-1:0]                  g_q;
  logic [i_Poly_Size-1:0]            poly_q;
  logic [o_Poly_Compressed_Size-1:0] pack_buf;
  logic [STEP_BITS-1:0]              grp_bits;

  // Threshold-count division: the numerator never exceeds 34424, so counting
  // multiples of Q (at most 10) is exact for every 12-bit input, including
  // x >= Q, and the final & 7 handles the wrap at 8.
  function automatic logic [2:0] compress3(input logic [data_Width-1:0] x);
    logic [15:0] v;
    logic [3:0]  q;
    v = {1'b0, x, 3'b000} + 16'd1664;
    q = '0;
    for (int k = 1; k <= 10; k++) begin
      if (v >= 16'(k * KYBER_Q)) q = q + 4'd1;
    end
    return q[2:0];
  endfunction

  // Compress the current group(s); the byte packing is a plain 3-bit stream.
  always_comb begin
    grp_bits = '0;
    for (int k = 0; k < COEF_PER_STEP; k++) begin
      grp_bits[3*k +: 3] =
        compress3(poly_q[(int'(g_q) * COEF_PER_STEP + k) * data_Width +: data_Width]);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = CALC;
      CALC:    if (g_q == G_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: input latch, group counter, pack buffer and published outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      g_q              <= '0;
      poly_q           <= '0;
      pack_buf         <= '0;
      busy             <= 1'b0;
      out_ready        <= 1'b0;
      oPoly_Compressed <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          out_ready <= 1'b0;
          if (enable) begin
            poly_q <= iPoly;
            g_q    <= '0;
            busy   <= 1'b1;
          end else begin
            busy   <= 1'b0;
          end
        end
        CALC: begin
          pack_buf[int'(g_q) * STEP_BITS +: STEP_BITS] <= grp_bits;
          g_q <= g_q + 1'b1;
        end
        DONE: begin
          oPoly_Compressed <= pack_buf;
          out_ready        <= 1'b1;
        end
        default: begin
          out_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
